// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: control/immediate inputs toward the PC logic and the
// three address outputs back to the pipeline and instruction memory.
interface fetch_unit_if;
  logic        B;
  logic        Z;
  logic        J;
  logic [25:0] target;
  logic [31:0] B_addr;
  logic [31:0] addr;
  logic [31:0] target_addr;
  logic [31:0] next_pc;

  // Decode/ALU side drives control and immediates, observes addresses
  modport master (
    output B, Z, J, target, B_addr,
    input  addr, target_addr, next_pc
  );

  // Fetch unit side
  modport slave (
    input  B, Z, J, target, B_addr,
    output addr, target_addr, next_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Program-counter fetch unit: holds the PC and selects jump, taken branch
// or sequential successor on every rising clock edge.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  fetch_unit_if.slave bus
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] seq_pc;
  logic [31:0] jump_pc;
  logic [31:0] branch_pc;

  // Sequential successor and the two redirect destinations
  always_comb begin
    seq_pc    = pc_reg + 32'd4;
    jump_pc   = {seq_pc[31:28], bus.target, 2'b00};
    branch_pc = seq_pc + {bus.B_addr[29:0], 2'b00};
  end

  // Next-PC priority: jump, then taken branch, then fall-through
  always_comb begin
    pc_next = seq_pc;
    if (bus.J) begin
      pc_next = jump_pc;
    end else if (bus.B && bus.Z) begin
      pc_next = branch_pc;
    end
  end

  // PC register; reset is asynchronous so a pending redirect is dropped at once
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign bus.addr        = pc_reg;
  assign bus.next_pc     = seq_pc;
  assign bus.target_addr = jump_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized traffic compared against a PC model.
module tb_fetch_unit;

  localparam logic [31:0] RP = 32'h0000_0000;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   model_on = 1'b0;
  logic [31:0] m_pc = RP;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RP)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end else begin
      $display("[TB] ok   %s: %08h", name, act);
    end
  endtask

  // Behavioural PC model: what the PC must be after each edge
  always @(posedge Clock or negedge Reset) begin
    logic [31:0] seq;
    if (!Reset) begin
      m_pc = RP;
    end else begin
      seq = m_pc + 32'd4;
      if (bus.J === 1'b1)
        m_pc = {seq[31:28], bus.target, 2'b00};
      else if (bus.B === 1'b1 && bus.Z === 1'b1)
        m_pc = seq + (bus.B_addr << 2);
      else
        m_pc = seq;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge Clock) begin
    logic [31:0] seq;
    if (model_on) begin
      seq = m_pc + 32'd4;
      chk("m_addr", bus.addr, m_pc);
      chk("m_next_pc", bus.next_pc, seq);
      chk("m_target_addr", bus.target_addr, {seq[31:28], bus.target, 2'b00});
    end
  end

  task automatic set_in(input logic j, input logic b, input logic z,
                        input logic [25:0] t, input logic [31:0] ba);
    bus.J = j; bus.B = b; bus.Z = z; bus.target = t; bus.B_addr = ba;
  endtask

  task automatic edge_chk(input string name, input logic [31:0] exp);
    @(posedge Clock);
    #1;
    chk(name, bus.addr, exp);
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #2;
    Reset = 1'b0;
    #1;
    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_next_pc", bus.next_pc, 32'h4);
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
    #3;
    model_on = 1'b1;
    chk("por_addr", bus.addr, 32'h0);

    // Sequential stepping from reset
    do_reset();
    edge_chk("seq1", 32'h4);
    edge_chk("seq2", 32'h8);
    edge_chk("seq3", 32'hC);
    chk("seq_next_pc", bus.next_pc, 32'h10);

    // Jump, then sequential
    do_reset();
    edge_chk("to4", 32'h4);
    set_in(1'b1, 1'b0, 1'b0, 26'h5, 32'h0);
    #1;
    chk("jmp_target_addr", bus.target_addr, 32'h14);
    edge_chk("jmp", 32'h14);
    set_in(1'b0, 1'b0, 1'b0, 26'h5, 32'h0);
    edge_chk("after_jmp", 32'h18);

    // Branch taken, self-loop, not taken
    do_reset();
    edge_chk("to4b", 32'h4);
    set_in(1'b1, 1'b0, 1'b0, 26'h5, 32'h0);
    edge_chk("jmp14", 32'h14);
    set_in(1'b0, 1'b1, 1'b1, 26'h0, 32'h3);
    edge_chk("br_taken", 32'h24);
    set_in(1'b0, 1'b1, 1'b1, 26'h0, 32'hFFFF_FFFF);
    edge_chk("br_self", 32'h24);
    edge_chk("br_self2", 32'h24);
    set_in(1'b0, 1'b1, 1'b0, 26'h0, 32'hFFFF_FFFF);
    edge_chk("br_z0", 32'h28);
    set_in(1'b0, 1'b0, 1'b1, 26'h0, 32'h40);
    edge_chk("br_b0", 32'h2C);

    // Jump priority over taken branch
    do_reset();
    edge_chk("to4c", 32'h4);
    set_in(1'b1, 1'b1, 1'b1, 26'h10, 32'h100);
    edge_chk("jmp_wins", 32'h40);

    // Max jump index and region carry via next_pc
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 26'h3FF_FFFF, 32'h0);
    edge_chk("jmp_max", 32'h0FFF_FFFC);
    chk("jmp_max_next", bus.next_pc, 32'h1000_0000);
    set_in(1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
    edge_chk("region_cross", 32'h1000_0000);

    // Branch to top of memory, next_pc wraps
    do_reset();
    set_in(1'b0, 1'b1, 1'b1, 26'h0, 32'hFFFF_FFFE);
    edge_chk("br_top", 32'hFFFF_FFFC);
    chk("wrap_next", bus.next_pc, 32'h0);
    set_in(1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
    edge_chk("wrap_pc", 32'h0);

    // Asynchronous reset overrides a pending jump
    edge_chk("pre_async", 32'h4);
    set_in(1'b1, 1'b0, 1'b0, 26'h123, 32'h0);
    @(posedge Clock);
    #3;
    chk("pre_async_jmp", bus.addr, 32'h48C);
    Reset = 1'b0;
    #1;
    chk("async_rst", bus.addr, 32'h0);
    edge_chk("rst_hold1", 32'h0);
    edge_chk("rst_hold2", 32'h0);
    @(negedge Clock);
    Reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 26'h0, 32'h0);
    edge_chk("rst_release", 32'h4);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 400; i++) begin
      @(posedge Clock);
      #1;
      bus.J      = ($urandom_range(0, 5) == 0);
      bus.B      = $urandom_range(0, 1);
      bus.Z      = $urandom_range(0, 1);
      bus.target = 26'($urandom);
      bus.B_addr = ($urandom_range(0, 1) != 0) ? 32'($signed(8'($urandom))) : 32'($urandom);
      if ($urandom_range(0, 40) == 0) begin
        #2;
        Reset = 1'b0;
        #1;
        chk("rnd_async_rst", bus.addr, RP);
        repeat ($urandom_range(0, 2)) @(posedge Clock);
        @(negedge Clock);
        #1;
        Reset = 1'b1;
      end
    end

    @(posedge Clock);
    #1;
    model_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded while reset is asserted.
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; Reset=0 forces PC to RESET_PC immediately, independent of Clock.
REQ-004 B  input  1  conditional-branch instruction flag, active high.
REQ-005 Z  input  1  ALU zero flag; branch taken only when B=1 and Z=1.
REQ-006 J  input  1  unconditional jump flag, active high.
REQ-007 target  input  26  jump instruction index field (instr[25:0]).
REQ-008 B_addr  input  32  sign-extended branch word offset (imm16 sign-extended to 32 bits, not yet shifted).
REQ-009 addr  output  32  current PC, i.e. the instruction-memory fetch address.
REQ-010 target_addr  output  32  computed jump destination.
REQ-011 next_pc  output  32  sequential successor address, addr+4.

Function
REQ-012 The block SHALL hold one 32-bit PC register; addr SHALL equal the register contents, with no combinational path from inputs to addr.
REQ-013 next_pc SHALL be combinational: addr + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-014 target_addr SHALL be combinational: {next_pc[31:28], target[25:0], 2'b00}.
REQ-015 Branch destination SHALL be next_pc + (B_addr << 2), 32-bit two's-complement, modulo 2^32; shifted-out upper bits of B_addr are discarded.
REQ-016 On each rising Clock edge with Reset=1, PC SHALL load, in priority order: target_addr if J=1; else branch destination if B=1 and Z=1; else next_pc.
REQ-017 J=1 together with B=1,Z=1 SHALL select the jump (J has priority).
REQ-018 B=1 with Z=0, or Z=1 with B=0, SHALL select next_pc.
REQ-019 Next-PC selection latency: inputs sampled at edge n appear on addr after edge n, i.e. one cycle; outputs target_addr/next_pc follow addr in the same cycle.
REQ-020 The block SHALL not check alignment; PC bits [1:0] stay 00 when RESET_PC is word-aligned, since all sources are word-aligned.
REQ-021 Inputs B, Z, J, target, B_addr SHALL be don't-care except at rising edges (and target also for the combinational target_addr output).

Reset
REQ-022 While Reset=0: addr=RESET_PC, next_pc=RESET_PC+4, target_addr derived per REQ-014; clock edges SHALL be ignored.
REQ-023 Reset assertion mid-operation SHALL override any pending jump/branch asynchronously; on deassertion, the first rising edge with Reset=1 performs a normal update from RESET_PC.
REQ-024 No other state exists; no output is X after reset.

Verification
REQ-025 Reset=0, then Reset=1, J=B=Z=0, three edges -> addr 0x0, 0x4, 0x8, 0xC; next_pc always addr+4.
REQ-026 At addr=0x4, J=1, target=26'h0000005 -> target_addr=0x0000_0014 before edge; after edge addr=0x14; J=0 next edge -> 0x18.
REQ-027 At addr=0x14: B=1,Z=1,B_addr=0x3 -> addr=0x24; B=1,Z=0 -> addr=0x18; B=1,Z=1,B_addr=0xFFFF_FFFF at addr=0x24 -> addr=0x24 (self-loop).
REQ-028 At addr=0x4: J=1,B=1,Z=1,target=26'h10,B_addr=0x100 -> addr=0x40 (jump wins).
REQ-029 J=1,target=26'h3FF_FFFF at addr=0x0 -> addr=0x0FFF_FFFC, next_pc=0x1000_0000; next sequential edge -> addr=0x1000_0000.
REQ-030 Pull Reset low between edges while J=1 -> addr=0x0 immediately, no clock needed; held low across two edges -> addr stays 0x0.
